// File: rtl/tx_pkg.sv
// Shared MAC transmit definitions: FSM encodings, frame size limits, line
// symbols and the CRC-32 step used by the framer's FCS generator.
package tx_pkg;

  typedef enum logic [2:0] {
    STATE_IDLE     = 3'h0,
    STATE_PREAMBLE = 3'h1,
    STATE_SFD      = 3'h2,
    STATE_DATA     = 3'h3,
    STATE_PAD      = 3'h4,
    STATE_FCS      = 3'h5,
    STATE_IFG      = 3'h6,
    STATE_DRAIN    = 3'h7
  } tx_state_e;

  localparam logic [3:0]  PREAMBLE_BYTES = 4'd7;
  localparam logic [3:0]  IFG_BYTES      = 4'd12;
  localparam logic [10:0] MIN_PAYLOAD    = 11'd60;
  localparam logic [10:0] MAX_PAYLOAD    = 11'd1514;

  localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;

  localparam logic [31:0] CRC_POLYNOMIAL = 32'h04C11DB7;
  localparam logic [31:0] CRC_SEED       = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE    = 32'hC704DD7B;

  function automatic logic [7:0] reverse8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Non-reflected register, but each byte enters LSB first as it goes on the wire.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLYNOMIAL : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/tx_crc.sv
// Byte-wide CRC-32 accumulator (DATA_WIDTH 8, CRC_WIDTH 32) for the MAC FCS.
// init reloads the seed and has priority over data_enable.
module tx_crc
  import tx_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        init,
  input  logic        data_enable,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      crc_out <= CRC_SEED;
    end else if (init) begin
      crc_out <= CRC_SEED;
    end else if (data_enable) begin
      crc_out <= crc32_byte(crc_out, data);
    end
  end

endmodule

// File: rtl/tx.sv
// Ethernet MAC transmit framer: pops bytes from a show-ahead FIFO and emits
// preamble, SFD, payload, zero pad, FCS and the inter-frame gap on a byte-wide TX bus.
module tx
  import tx_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_in_end,
  input  logic       fifo_empty,
  output logic       fifo_read,
  output logic       tx_data_valid,
  output logic [7:0] tx_data,
  output logic       tx_error,
  output logic       busy,
  output logic [2:0] debug_state
);

  // FIFO handshake: the head byte on data_in is valid whenever fifo_empty is low,
  // and it is consumed in any cycle where fifo_read is high (no other qualifier).

  tx_state_e   state, state_next;
  logic [3:0]  phase, phase_next;
  logic [10:0] byte_count, count_next;

  logic        valid_next;
  logic        error_next;
  logic [7:0]  data_next;
  logic        crc_init;
  logic        crc_enable;
  logic [31:0] crc_out;
  logic [7:0]  fcs_byte;
  logic        at_max;

  assign at_max      = (byte_count == MAX_PAYLOAD);
  assign busy        = (state != STATE_IDLE);
  assign debug_state = state;

  tx_crc u_crc (
    .clock       (clock),
    .reset       (reset),
    .init        (crc_init),
    .data_enable (crc_enable),
    .data        (data_next),
    .crc_out     (crc_out)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= STATE_IDLE;
      phase         <= 4'd0;
      byte_count    <= 11'd0;
      tx_data_valid <= 1'b0;
      tx_data       <= 8'h00;
      tx_error      <= 1'b0;
    end else begin
      state         <= state_next;
      phase         <= phase_next;
      byte_count    <= count_next;
      tx_data_valid <= valid_next;
      tx_data       <= data_next;
      tx_error      <= error_next;
    end
  end

  always_comb begin
    state_next = state;
    phase_next = phase;
    count_next = byte_count;
    case (state)
      STATE_IDLE: begin
        phase_next = 4'd0;
        count_next = 11'd0;
        if (!fifo_empty) state_next = STATE_PREAMBLE;
      end
      STATE_PREAMBLE: begin
        if (phase == PREAMBLE_BYTES - 4'd1) begin
          state_next = STATE_SFD;
          phase_next = 4'd0;
        end else begin
          phase_next = phase + 4'd1;
        end
      end
      STATE_SFD: state_next = STATE_DATA;
      STATE_DATA: begin
        if (at_max || fifo_empty) begin
          state_next = STATE_DRAIN;
        end else begin
          count_next = byte_count + 11'd1;
          if (data_in_end)
            state_next = ((byte_count + 11'd1) < MIN_PAYLOAD) ? STATE_PAD : STATE_FCS;
        end
      end
      STATE_PAD: begin
        count_next = byte_count + 11'd1;
        if ((byte_count + 11'd1) == MIN_PAYLOAD) state_next = STATE_FCS;
      end
      STATE_FCS: begin
        if (phase == 4'd3) begin
          state_next = STATE_IFG;
          phase_next = 4'd0;
        end else begin
          phase_next = phase + 4'd1;
        end
      end
      STATE_IFG: begin
        // The IDLE decision cycle is the last gap byte, so back-to-back frames
        // see exactly IFG_BYTES idle cycles on the wire.
        if (phase == IFG_BYTES - 4'd2) begin
          state_next = STATE_IDLE;
          phase_next = 4'd0;
        end else begin
          phase_next = phase + 4'd1;
        end
      end
      STATE_DRAIN: begin
        if (!fifo_empty && data_in_end) state_next = STATE_IFG;
      end
      default: state_next = STATE_IDLE;
    endcase
  end

  always_comb begin
    case (phase[1:0])
      2'd0:    fcs_byte = ~reverse8(crc_out[31:24]);
      2'd1:    fcs_byte = ~reverse8(crc_out[23:16]);
      2'd2:    fcs_byte = ~reverse8(crc_out[15:8]);
      default: fcs_byte = ~reverse8(crc_out[7:0]);
    endcase
  end

  always_comb begin
    fifo_read  = 1'b0;
    valid_next = 1'b0;
    error_next = 1'b0;
    data_next  = 8'h00;
    crc_init   = 1'b0;
    crc_enable = 1'b0;
    case (state)
      STATE_PREAMBLE: begin
        valid_next = 1'b1;
        data_next  = PREAMBLE_BYTE;
      end
      STATE_SFD: begin
        valid_next = 1'b1;
        data_next  = SFD_BYTE;
        crc_init   = 1'b1;
      end
      STATE_DATA: begin
        valid_next = 1'b1;
        if (at_max || fifo_empty) begin
          error_next = 1'b1;
        end else begin
          fifo_read  = 1'b1;
          data_next  = data_in;
          crc_enable = 1'b1;
        end
      end
      STATE_PAD: begin
        valid_next = 1'b1;
        crc_enable = 1'b1;
      end
      STATE_FCS: begin
        valid_next = 1'b1;
        data_next  = fcs_byte;
      end
      STATE_DRAIN: fifo_read = !fifo_empty;
      default: ;
    endcase
  end

endmodule
